// File: rtl/seq_step_counter.sv
// ============================================================================
// Module   : seq_step_counter
// Purpose  : One-shot / auto-repeating step sequencer (cnt runs 1..LAST, 0 = idle)
//            with hold, abort, done/aborted pulses and a completed-run counter.
//            Define SEQ_STEP_COUNTER_LOAD_EN to add a runtime-loadable terminal step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_step_counter #(
    parameter int WIDTH = 3,
    parameter int LAST  = 5,
    parameter int RUN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic             repeat_en,
`ifdef SEQ_STEP_COUNTER_LOAD_EN
    input  logic             ld_en,
    input  logic [WIDTH-1:0] ld_last,
`endif
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [RUN_W-1:0] run_cnt
);

    localparam logic [WIDTH-1:0] c_LAST = WIDTH'(LAST);
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_ZERO = '0;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    logic [WIDTH-1:0] r_cnt;
    logic             r_done;
    logic             r_aborted;
    logic [RUN_W-1:0] r_run_cnt;

    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_done_nxt;
    logic             w_aborted_nxt;
    logic [RUN_W-1:0] w_run_cnt_nxt;
    logic [WIDTH-1:0] w_term;
    state_t           w_state;

`ifdef SEQ_STEP_COUNTER_LOAD_EN
    logic [WIDTH-1:0] r_term;

    // Terminal step may only change while idle and not launching, so a run
    // always completes against the value it started with.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_term <= c_LAST;
        end else if (ld_en && (r_cnt == c_ZERO) && !start) begin
            r_term <= (ld_last == c_ZERO) ? c_ONE : ld_last;
        end
    end

    assign w_term = r_term;
`else
    assign w_term = c_LAST;
`endif

    // The step value itself is the state register; the enum only names it.
    assign w_state = (r_cnt == c_ZERO) ? S_IDLE : S_RUN;

    always_comb begin
        w_cnt_nxt     = r_cnt;
        w_done_nxt    = 1'b0;
        w_aborted_nxt = 1'b0;
        w_run_cnt_nxt = r_run_cnt;
        case (w_state)
            S_IDLE: begin
                if (start && !hold && !abort) begin
                    w_cnt_nxt = c_ONE;
                end
            end
            S_RUN: begin
                if (r_cnt > w_term) begin
                    // Unreachable value (upset or bad load): recover silently.
                    w_cnt_nxt = c_ZERO;
                end else if (abort) begin
                    w_cnt_nxt     = c_ZERO;
                    w_aborted_nxt = 1'b1;
                end else if (hold) begin
                    w_cnt_nxt = r_cnt;
                end else if (r_cnt < w_term) begin
                    w_cnt_nxt = r_cnt + c_ONE;
                end else begin
                    w_done_nxt    = 1'b1;
                    w_run_cnt_nxt = r_run_cnt + RUN_W'(1);
                    w_cnt_nxt     = (repeat_en || start) ? c_ONE : c_ZERO;
                end
            end
            default: begin
                w_cnt_nxt = c_ZERO;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt     <= c_ZERO;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
            r_run_cnt <= '0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_done    <= w_done_nxt;
            r_aborted <= w_aborted_nxt;
            r_run_cnt <= w_run_cnt_nxt;
        end
    end

    assign cnt     = r_cnt;
    assign busy    = |r_cnt;
    assign done    = r_done;
    assign aborted = r_aborted;
    assign run_cnt = r_run_cnt;

endmodule

`default_nettype wire

// File: tb/tb_seq_step_counter.sv
// Scoreboarded bench for seq_step_counter (WIDTH=3, LAST=5, RUN_W=8); the load
// scenario is exercised only when SEQ_STEP_COUNTER_LOAD_EN is defined.
`default_nettype none

module tb_seq_step_counter;

    typedef struct packed {
        logic [2:0] cnt;
        logic       d;
        logic       ab;
        logic [7:0] run;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       hold = 1'b0;
    logic       repeat_en = 1'b0;
    logic       ld_en = 1'b0;
    logic [2:0] ld_last = 3'd0;
    logic [2:0] cnt;
    logic       busy;
    logic       done;
    logic       aborted;
    logic [7:0] run_cnt;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    seq_step_counter #(.WIDTH(3), .LAST(5), .RUN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .hold      (hold),
        .repeat_en (repeat_en),
`ifdef SEQ_STEP_COUNTER_LOAD_EN
        .ld_en     (ld_en),
        .ld_last   (ld_last),
`endif
        .cnt       (cnt),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .run_cnt   (run_cnt)
    );

    function automatic exp_t mk(input int c, input int d, input int ab, input int run);
        mk.cnt = 3'(c);
        mk.d   = 1'(d);
        mk.ab  = 1'(ab);
        mk.run = 8'(run);
    endfunction

    // Drive {start,abort,hold,repeat_en} for the next edge and queue the
    // outputs expected after that edge.
    task automatic apply(input logic [3:0] iv, input exp_t e);
        {start, abort, hold, repeat_en} = iv;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0;
        sb.push_back(mk(0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        e = sb.pop_front();
        n_tests++;
        if ({cnt, done, aborted, run_cnt, busy} !== {e.cnt, e.d, e.ab, e.run, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: got cnt=%0d done=%0b ab=%0b run=%0d busy=%0b exp all zero",
                     cnt, done, aborted, run_cnt, busy);
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [3:0] iv [7];
        exp_t       ev [7];
        exp_t       e;
        iv = '{4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        ev = '{mk(1,0,0,0), mk(2,0,0,0), mk(3,0,0,0), mk(4,0,0,0),
               mk(5,0,0,0), mk(0,1,0,1), mk(0,0,0,1)};
        for (int i = 0; i < 7; i++) begin
            apply(iv[i], ev[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_tests++;
            if ({cnt, done, aborted, run_cnt, busy} !== {e.cnt, e.d, e.ab, e.run, |e.cnt}) begin
                n_fail++;
                $display("FAIL basic cyc%0d: got cnt=%0d done=%0b ab=%0b run=%0d busy=%0b exp cnt=%0d done=%0b ab=%0b run=%0d",
                         i, cnt, done, aborted, run_cnt, busy, e.cnt, e.d, e.ab, e.run);
            end
        end
    endtask

    task automatic test_repeat();
        exp_t e;
        for (int i = 0; i < 17; i++) begin
            // Three full runs with repeat_en, then drop it on the third LAST.
            if (i == 0)       apply(4'b1001, mk(1, 0, 0, 1));
            else if (i == 16) apply(4'b0000, mk(0, 0, 0, 4));
            else if (i == 15) apply(4'b0000, mk(0, 1, 0, 4));
            else if (i % 5 == 0) apply(4'b0001, mk(1, 1, 0, 1 + i / 5));
            else              apply(4'b0001, mk(i % 5 + 1, 0, 0, 1 + i / 5));
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_tests++;
            if ({cnt, done, aborted, run_cnt, busy} !== {e.cnt, e.d, e.ab, e.run, |e.cnt}) begin
                n_fail++;
                $display("FAIL repeat cyc%0d: got cnt=%0d done=%0b ab=%0b run=%0d busy=%0b exp cnt=%0d done=%0b ab=%0b run=%0d",
                         i, cnt, done, aborted, run_cnt, busy, e.cnt, e.d, e.ab, e.run);
            end
        end
    endtask

    task automatic test_hold();
        logic [3:0] iv [10];
        exp_t       ev [10];
        exp_t       e;
        int         busy_cycles = 0;
        iv = '{4'b1000, 4'b0000, 4'b0000, 4'b0010, 4'b1010,
               4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000};
        ev = '{mk(1,0,0,4), mk(2,0,0,4), mk(3,0,0,4), mk(3,0,0,4), mk(3,0,0,4),
               mk(3,0,0,4), mk(3,0,0,4), mk(4,0,0,4), mk(5,0,0,4), mk(0,1,0,5)};
        for (int i = 0; i < 10; i++) begin
            apply(iv[i], ev[i]);
            @(posedge clk);
            #1;
            if (busy === 1'b1) busy_cycles++;
            e = sb.pop_front();
            n_tests++;
            if ({cnt, done, aborted, run_cnt, busy} !== {e.cnt, e.d, e.ab, e.run, |e.cnt}) begin
                n_fail++;
                $display("FAIL hold cyc%0d: got cnt=%0d done=%0b ab=%0b run=%0d busy=%0b exp cnt=%0d done=%0b ab=%0b run=%0d",
                         i, cnt, done, aborted, run_cnt, busy, e.cnt, e.d, e.ab, e.run);
            end
        end
        n_tests++;
        if (busy_cycles != 9) begin
            n_fail++;
            $display("FAIL hold_busy_cycles: got %0d exp 9", busy_cycles);
        end
    endtask

    task automatic test_abort();
        logic [3:0] iv [17];
        exp_t       ev [17];
        exp_t       e;
        iv = '{4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000,
               4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100, 4'b0000,
               4'b1000, 4'b0110, 4'b0000, 4'b1010, 4'b0000};
        ev = '{mk(1,0,0,5), mk(2,0,0,5), mk(0,0,1,5), mk(0,0,0,5), mk(1,0,0,5),
               mk(2,0,0,5), mk(3,0,0,5), mk(4,0,0,5), mk(5,0,0,5), mk(0,0,1,5),
               mk(0,0,0,5), mk(0,0,0,5), mk(1,0,0,5), mk(0,0,1,5), mk(0,0,0,5),
               mk(0,0,0,5), mk(0,0,0,5)};
        for (int i = 0; i < 17; i++) begin
            apply(iv[i], ev[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_tests++;
            if ({cnt, done, aborted, run_cnt, busy} !== {e.cnt, e.d, e.ab, e.run, |e.cnt}) begin
                n_fail++;
                $display("FAIL abort cyc%0d: got cnt=%0d done=%0b ab=%0b run=%0d busy=%0b exp cnt=%0d done=%0b ab=%0b run=%0d",
                         i, cnt, done, aborted, run_cnt, busy, e.cnt, e.d, e.ab, e.run);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] iv [9];
        exp_t       ev [9];
        exp_t       e;
        iv = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b1000,
               4'b1000, 4'b0000, 4'b1000, 4'b0000};
        ev = '{mk(1,0,0,5), mk(2,0,0,5), mk(3,0,0,5), mk(4,0,0,5), mk(5,0,0,5),
               mk(1,1,0,6), mk(2,0,0,6), mk(3,0,0,6), mk(4,0,0,6)};
        for (int i = 0; i < 9; i++) begin
            apply(iv[i], ev[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_tests++;
            if ({cnt, done, aborted, run_cnt, busy} !== {e.cnt, e.d, e.ab, e.run, |e.cnt}) begin
                n_fail++;
                $display("FAIL b2b cyc%0d: got cnt=%0d done=%0b ab=%0b run=%0d busy=%0b exp cnt=%0d done=%0b ab=%0b run=%0d",
                         i, cnt, done, aborted, run_cnt, busy, e.cnt, e.d, e.ab, e.run);
            end
        end
        // Asynchronous reset between edges, with cnt=4 in flight.
        #2;
        rst = 1'b0;
        sb.push_back(mk(0, 0, 0, 0));
        #1;
        e = sb.pop_front();
        n_tests++;
        if ({cnt, done, aborted, run_cnt, busy} !== {e.cnt, e.d, e.ab, e.run, 1'b0}) begin
            n_fail++;
            $display("FAIL async_rst: got cnt=%0d done=%0b ab=%0b run=%0d busy=%0b exp all zero",
                     cnt, done, aborted, run_cnt, busy);
        end
        sb.push_back(mk(0, 0, 0, 0));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_tests++;
        if ({cnt, done, aborted, run_cnt, busy} !== {e.cnt, e.d, e.ab, e.run, 1'b0}) begin
            n_fail++;
            $display("FAIL async_rst_hold: got cnt=%0d done=%0b ab=%0b run=%0d busy=%0b exp all zero",
                     cnt, done, aborted, run_cnt, busy);
        end
        rst = 1'b1;
    endtask

`ifdef SEQ_STEP_COUNTER_LOAD_EN
    task automatic test_load();
        logic [3:0] iv [9];
        logic [3:0] lv [9];
        exp_t       ev [9];
        exp_t       e;
        iv = '{4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000,
               4'b1000, 4'b0000, 4'b1000, 4'b0000};
        // {ld_en, ld_last}
        lv = '{4'b1010, 4'b0000, 4'b1000, 4'b0000, 4'b1000,
               4'b0000, 4'b0000, 4'b1011, 4'b0000};
        ev = '{mk(0,0,0,0), mk(1,0,0,0), mk(2,0,0,0), mk(0,1,0,1), mk(0,0,0,1),
               mk(1,0,0,1), mk(0,1,0,2), mk(1,0,0,2), mk(0,1,0,3)};
        for (int i = 0; i < 9; i++) begin
            {ld_en, ld_last} = lv[i];
            apply(iv[i], ev[i]);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            n_tests++;
            if ({cnt, done, aborted, run_cnt, busy} !== {e.cnt, e.d, e.ab, e.run, |e.cnt}) begin
                n_fail++;
                $display("FAIL load cyc%0d: got cnt=%0d done=%0b ab=%0b run=%0d busy=%0b exp cnt=%0d done=%0b ab=%0b run=%0d",
                         i, cnt, done, aborted, run_cnt, busy, e.cnt, e.d, e.ab, e.run);
            end
        end
        {ld_en, ld_last} = 4'b0000;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_repeat();
        test_hold();
        test_abort();
        test_back_to_back();
`ifdef SEQ_STEP_COUNTER_LOAD_EN
        test_load();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
